// File: rtl/nios2_oci_dct_capture_if.sv
// Trace-capture port bundle: OCI frame input, end-of-test controls,
// pop interface and buffer status.
interface nios2_oci_dct_capture_if #(
   parameter int FRAME_W = 30,
   parameter int COUNT_W = 4,
   parameter int DEPTH   = 16
);
   localparam int AW = $clog2(DEPTH);

   logic [FRAME_W-1:0]         dct_buffer;
   logic [COUNT_W-1:0]         dct_count;
   logic                       dct_valid;
   logic                       test_ending;
   logic                       test_has_ended;
   logic                       rd_req;
   logic [COUNT_W+FRAME_W-1:0] rd_data;
   logic                       rd_valid;
   logic [AW:0]                level;
   logic                       empty;
   logic                       full;
   logic [15:0]                overflow_cnt;
   logic [1:0]                 state;
   logic                       flush_done;

   modport master (
      output dct_buffer, dct_count, dct_valid,
      output test_ending, test_has_ended, rd_req,
      input  rd_data, rd_valid, level, empty, full,
      input  overflow_cnt, state, flush_done
   );

   modport slave (
      input  dct_buffer, dct_count, dct_valid,
      input  test_ending, test_has_ended, rd_req,
      output rd_data, rd_valid, level, empty, full,
      output overflow_cnt, state, flush_done
   );
endinterface

// File: rtl/nios2_oci_dct_capture.sv
// OCI trace sink: DEPTH-entry frame buffer with wrap/stop-on-full,
// saturating loss counter and end-of-test drain sequence.
module nios2_oci_dct_capture #(
   parameter int FRAME_W   = 30,
   parameter int COUNT_W   = 4,
   parameter int DEPTH     = 16,
   parameter bit MODE_WRAP = 1'b1
) (
   input logic clk,
   input logic reset_n,
   nios2_oci_dct_capture_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = COUNT_W + FRAME_W;

   typedef enum logic [1:0] {
      CAPTURE = 2'd0,
      DRAIN   = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level_q;
   logic [DW-1:0] rd_data_q;
   logic          rd_valid_q;
   logic [15:0]   ovf_q;

   logic empty, full, wr, rd, lost, store, adv_rd, inc, dec;

   assign empty = (level_q == '0);
   assign full  = (level_q == (AW+1)'(DEPTH));
   assign wr    = bus.dct_valid && (bus.dct_count != '0)
                  && (state_q == CAPTURE);
   assign rd    = bus.rd_req && !empty;

   // a full buffer only loses a frame when no pop frees a slot
   assign lost   = wr && full && !rd;
   assign store  = wr && (!full || rd || MODE_WRAP);
   assign adv_rd = rd || (lost && MODE_WRAP);
   assign inc    = wr && !full;
   assign dec    = rd && !(wr && full);

   always_ff @(posedge clk) begin
      if (store)
         mem[wr_ptr] <= {bus.dct_count, bus.dct_buffer};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= '0;
      end else begin
         rd_valid_q <= rd;
         if (rd)
            rd_data_q <= mem[rd_ptr];
         if (store)
            wr_ptr <= wr_ptr + AW'(1);
         if (adv_rd)
            rd_ptr <= rd_ptr + AW'(1);
         if (inc && !dec)
            level_q <= level_q + (AW+1)'(1);
         else if (dec && !inc)
            level_q <= level_q - (AW+1)'(1);
         if (lost && (ovf_q != 16'hFFFF))
            ovf_q <= ovf_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_q <= CAPTURE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         CAPTURE:
            if (bus.test_ending || bus.test_has_ended)
               state_d = DRAIN;
         DRAIN:
            if (empty && bus.test_has_ended)
               state_d = DONE;
         DONE:
            state_d = DONE;
         default:
            state_d = CAPTURE;
      endcase
   end

   assign bus.rd_data      = rd_data_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.level        = level_q;
   assign bus.empty        = empty;
   assign bus.full         = full;
   assign bus.overflow_cnt = ovf_q;
   assign bus.state        = state_q;
   assign bus.flush_done   = (state_q == DONE);
endmodule

// File: doc/nios2_oci_dct_capture.md
Name: nios2_oci_dct_capture

Overview:
Parametrised successor to the OCI test-bench trace sink. Captures compressed trace frames (dct_buffer plus dct_count nibble count) from the OCI into a DEPTH-entry buffer and provides a read port for the bench or JTAG readout. Adds selectable wrap or stop-on-full mode, a saturating overflow counter, and an end-of-test drain/flush sequence driven by test_ending and test_has_ended. Sits between the nios2_oci trace compressor and the simulation monitor or debug readout logic.

Parameters:
FRAME_W, 30, width of dct_buffer frame
COUNT_W, 4, width of dct_count (valid nibbles in frame)
DEPTH, 16, buffer entries; power of two, >=2
MODE_WRAP, 1, 1 = overwrite oldest entry when full; 0 = drop new frame when full
AW, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
clk  in  1  single clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
dct_buffer  in  FRAME_W  compressed trace frame
dct_count  in  COUNT_W  valid nibble count of frame; 0 = no data
dct_valid  in  1  frame strobe, one frame per cycle
test_ending  in  1  level; request end of capture
test_has_ended  in  1  level; bench has stopped stimulus
rd_req  in  1  pop request
rd_data  out  COUNT_W+FRAME_W  {count,frame} of popped entry
rd_valid  out  1  one-cycle pulse qualifying rd_data
level  out  AW+1  entries held, 0..DEPTH
empty  out  1  level==0
full  out  1  level==DEPTH
overflow_cnt  out  16  frames lost or overwritten, saturating
state  out  2  0=CAPTURE, 1=DRAIN, 2=DONE
flush_done  out  1  sticky; buffer drained after test end

Behaviour:
- Reset (async assert, sync release): pointers=0, level=0, empty=1, full=0, rd_data=0, rd_valid=0, overflow_cnt=0, state=CAPTURE, flush_done=0. Assertion mid-operation discards all contents immediately.
- Write qualifier wr = dct_valid && dct_count!=0 && state==CAPTURE. dct_valid with count 0 is ignored and not counted.
- Read qualifier rd = rd_req && !empty, in any state. rd_req on empty is ignored; no rd_valid is produced.
- Read latency 1: rd_data and rd_valid are registered on the cycle after rd. rd_data holds its value until the next pop. rd_valid is low otherwise.
- Write latency: entry is visible (level/empty updated) on the cycle after wr.
- wr and !full: store at wr_ptr, wr_ptr++, level++.
- wr, full, rd: pop oldest, store new; level stays DEPTH; no overflow.
- wr, full, !rd, MODE_WRAP=1: overwrite oldest, wr_ptr++, rd_ptr++, level stays DEPTH, overflow_cnt++.
- wr, full, !rd, MODE_WRAP=0: frame dropped, overflow_cnt++.
- Pointers wrap modulo DEPTH. overflow_cnt saturates at 16'hFFFF.
- FSM transitions:
  - CAPTURE -> DRAIN when test_ending or test_has_ended. A wr in the transition cycle is still accepted.
  - DRAIN: writes blocked, reads allowed. DRAIN -> DONE when empty && test_has_ended, also when both occur in the same cycle as the last pop completing.
  - DONE: flush_done=1, sticky until reset. Reads on empty are ignored. No exit except reset.
- Deassertion of test_ending in DRAIN has no effect; there is no return to CAPTURE.

Test Plan:
- Reset with buffer half full (level=8) -> next cycle level=0, empty=1, overflow_cnt=0, state=0.
- Write frames 0x1..0x5 (count=4), then pop 5 times -> rd_data {4,0x1}..{4,0x5} in order, each rd_valid one cycle after rd_req; after the 5th pop empty=1.
- MODE_WRAP=1, DEPTH=16: write 20 frames without reads -> level=16, overflow_cnt=4, first pop returns frame #5.
- MODE_WRAP=0: same stimulus -> overflow_cnt=4, first pop returns frame #1, last returns #16.
- Full buffer, simultaneous wr and rd for 3 cycles -> level stays 16, overflow_cnt unchanged, oldest 3 popped in order.
- Write 3 frames, assert test_ending, keep dct_valid high with count=7, assert test_has_ended, pop 3 -> no new entries written; state goes 0->1->2; flush_done=1 on the cycle after empty && test_has_ended; dct_valid with count=0 never changes level.
